// File: rtl/mem_stream_pkg.sv
// Shared types and sizing helpers for the memory frame streamer.
package mem_stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int ADDR_LENGTH_DFLT = 14;

    // One extra bit so a full 2**addr_length frame count is representable.
    function automatic int cnt_width(input int addr_length);
        return addr_length + 1;
    endfunction

    localparam int CNT_W = cnt_width(ADDR_LENGTH_DFLT);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO that absorbs the memory read latency, plus its occupancy checker.
module stream_fifo2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;

    // Storage, pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r[0] <= {DATA_WIDTH{1'b0}};
            mem_r[1] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    stream_fifo2_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

module stream_fifo2_chk (
    input logic       clk,
    input logic       reset,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == 2'd2)));

    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(pop && (count == 2'd0)));

endmodule

// File: rtl/mem_frame_streamer.sv
// Reads one frame from a 1-cycle-latency memory and streams it out as valid/ready with a last marker.
module mem_frame_streamer
    import mem_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_LENGTH = 14,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_LENGTH-1:0] base_addr,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_LENGTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0]  rddata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last
);

    localparam int             CW          = cnt_width(ADDR_LENGTH);
    localparam logic [CW-1:0]  FRAME_LEN_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_IDX_C  = CW'(FRAME_LEN - 1);

    state_t                  state_r;
    logic                    busy_r;
    logic [ADDR_LENGTH-1:0]  rdaddr_r;
    logic [CW-1:0]           issued_r;
    logic [CW-1:0]           beats_r;
    logic                    rd_pending_r;

    logic [1:0]              fifo_count_s;
    logic [DATA_WIDTH-1:0]   fifo_head_s;
    logic                    valid_s;
    logic                    pop_s;
    logic                    last_s;
    logic                    issue_s;
    logic [2:0]              occ_s;

    assign valid_s = (fifo_count_s != 2'd0);
    assign pop_s   = valid_s & m_ready;
    assign last_s  = valid_s & (beats_r == LAST_IDX_C);

    // Issue decision; a slot freed by this cycle's pop is reusable so a held-high m_ready sustains 1 word/cycle.
    always_comb begin
        occ_s = {1'b0, fifo_count_s} + {2'b00, rd_pending_r} - {2'b00, pop_s};
        if ((state_r == STREAM) && (issued_r < FRAME_LEN_C) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Frame FSM with issue counter, accepted-beat counter and read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            rdaddr_r     <= {ADDR_LENGTH{1'b0}};
            issued_r     <= {CW{1'b0}};
            beats_r      <= {CW{1'b0}};
            rd_pending_r <= 1'b0;
        end else begin
            rd_pending_r <= issue_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= STREAM;
                        busy_r   <= 1'b1;
                        rdaddr_r <= base_addr;
                        issued_r <= {CW{1'b0}};
                        beats_r  <= {CW{1'b0}};
                    end
                end
                STREAM: begin
                    if (issue_s) begin
                        rdaddr_r <= rdaddr_r + ADDR_LENGTH'(1'b1);
                        issued_r <= issued_r + CW'(1'b1);
                    end
                    if (pop_s && last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        beats_r <= {CW{1'b0}};
                    end else if (pop_s) begin
                        beats_r <= beats_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pending_r),
        .push_data (rddata),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    assign busy    = busy_r;
    assign done    = pop_s & last_s;
    assign rdaddr  = rdaddr_r;
    assign m_valid = valid_s;
    assign m_data  = fifo_head_s;
    assign m_last  = last_s;

endmodule

// File: tb/tb_mem_frame_streamer.sv
// Directed bench: three streamers (FRAME_LEN 8, 16, 1) each reading from a shared preloaded memory model.
module tb_mem_frame_streamer;

    localparam int DW = 32;
    localparam int AL = 14;
    localparam int FL [3] = '{8, 16, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    start;
    logic [2:0]    busy;
    logic [2:0]    done;
    logic [2:0]    m_valid;
    logic [2:0]    m_ready;
    logic [2:0]    m_last;
    logic [AL-1:0] base_addr [3];
    logic [AL-1:0] rdaddr    [3];
    logic [DW-1:0] m_data    [3];
    logic [DW-1:0] mem [0:(1<<AL)-1];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [DW-1:0] rd_q;
        always_ff @(posedge clk) rd_q <= mem[rdaddr[g]];

        mem_frame_streamer #(
            .DATA_WIDTH  (DW),
            .ADDR_LENGTH (AL),
            .FRAME_LEN   (FL[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start[g]),
            .base_addr (base_addr[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .rdaddr    (rdaddr[g]),
            .rddata    (rd_q),
            .m_valid   (m_valid[g]),
            .m_ready   (m_ready[g]),
            .m_data    (m_data[g]),
            .m_last    (m_last[g])
        );
    end

    typedef struct packed {
        logic [1:0]       dut;
        logic [13:0]      base;
        logic [3:0]       n;
        logic [7:0][31:0] exp;
    } frame_vec_t;

    frame_vec_t vecs [4];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats with m_ready high; expects consecutive words starting at 'first'.
    task automatic stream_ready(input int d, input int n, input logic [31:0] first,
                                input int beat0, input int flen);
        int cnt;
        m_ready[d] = 1'b1;
        #1;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            while (!m_valid[d] && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("beat_valid", 32'(m_valid[d]), 32'd1);
            chk("beat_data", m_data[d], first + 32'(k));
            chk("beat_last", 32'(m_last[d]), 32'((beat0 + k) == flen - 1));
            chk("beat_done", 32'(done[d]), 32'((beat0 + k) == flen - 1));
            tick();
        end
    endtask

    task automatic start_frame(input int d, input logic [AL-1:0] base);
        base_addr[d] = base;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int got;
        logic stall_prev;
        logic [DW-1:0] prev_data;
        logic prev_last;
        logic [AL-1:0] frozen;

        for (int i = 0; i < (1 << AL); i++) mem[i] = 32'(i);
        start   = 3'b000;
        m_ready = 3'b000;
        for (int i = 0; i < 3; i++) base_addr[i] = 14'h0000;

        vecs[0] = '{dut: 2'd0, base: 14'h0010, n: 4'd8,
                    exp: {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10}};
        vecs[1] = '{dut: 2'd0, base: 14'h3FFC, n: 4'd8,
                    exp: {32'h0003, 32'h0002, 32'h0001, 32'h0000, 32'h3FFF, 32'h3FFE, 32'h3FFD, 32'h3FFC}};
        vecs[2] = '{dut: 2'd2, base: 14'h3FFF, n: 4'd1,
                    exp: {224'd0, 32'h3FFF}};
        vecs[3] = '{dut: 2'd2, base: 14'h0005, n: 4'd1,
                    exp: {224'd0, 32'h0005}};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_valid", 32'(m_valid[i]), 32'd0);
            chk("rst_last", 32'(m_last[i]), 32'd0);
            chk("rst_rdaddr", 32'(rdaddr[i]), 32'd0);
        end
        reset = 1'b0;
        tick();

        // Table-driven full frames with m_ready held high
        for (int i = 0; i < 4; i++) begin
            d = int'(vecs[i].dut);
            m_ready[d] = 1'b1;
            start_frame(d, vecs[i].base);
            chk("busy_after_start", 32'(busy[d]), 32'd1);
            chk("no_valid_c1", 32'(m_valid[d]), 32'd0);
            tick();
            chk("no_valid_c2", 32'(m_valid[d]), 32'd0);
            tick();
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                chk("vec_valid", 32'(m_valid[d]), 32'd1);
                chk("vec_data", m_data[d], vecs[i].exp[k]);
                chk("vec_last", 32'(m_last[d]), 32'(k == int'(vecs[i].n) - 1));
                chk("vec_done", 32'(done[d]), 32'(k == int'(vecs[i].n) - 1));
                tick();
            end
            chk("vec_busy_end", 32'(busy[d]), 32'd0);
            chk("vec_valid_end", 32'(m_valid[d]), 32'd0);
            tick();
        end

        // Random backpressure, 16-word frame
        m_ready[1] = 1'b0;
        start_frame(1, 14'h0000);
        got = 0;
        stall_prev = 1'b0;
        prev_data = 32'd0;
        prev_last = 1'b0;
        for (int c = 0; c < 400 && got < 16; c++) begin
            m_ready[1] = 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid[1]), 32'd1);
                chk("stall_data", m_data[1], prev_data);
                chk("stall_last", 32'(m_last[1]), 32'(prev_last));
            end
            if (m_valid[1] && m_ready[1]) begin
                chk("rnd_data", m_data[1], 32'(got));
                chk("rnd_last", 32'(m_last[1]), 32'(got == 15));
                chk("rnd_done", 32'(done[1]), 32'(got == 15));
                got++;
            end
            stall_prev = m_valid[1] & ~m_ready[1];
            prev_data  = m_data[1];
            prev_last  = m_last[1];
            tick();
        end
        chk("rnd_beats", 32'(got), 32'd16);
        chk("rnd_busy_end", 32'(busy[1]), 32'd0);
        tick();

        // Long stall mid-frame
        start_frame(1, 14'h0040);
        stream_ready(1, 5, 32'h40, 0, 16);
        m_ready[1] = 1'b0;
        frozen = 14'h0000;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 2) frozen = rdaddr[1];
        end
        chk("stall_rdaddr", 32'(rdaddr[1]), 32'h0047);
        chk("stall_rdaddr_frozen", 32'(rdaddr[1]), 32'(frozen));
        chk("stall_head", m_data[1], 32'h45);
        chk("stall_busy", 32'(busy[1]), 32'd1);
        stream_ready(1, 11, 32'h45, 5, 16);
        chk("stall_busy_end", 32'(busy[1]), 32'd0);

        // Start pulsed while busy is ignored
        start_frame(1, 14'h0060);
        stream_ready(1, 3, 32'h60, 0, 16);
        base_addr[1] = 14'h0100;
        start[1] = 1'b1;
        stream_ready(1, 1, 32'h63, 3, 16);
        start[1] = 1'b0;
        stream_ready(1, 12, 32'h64, 4, 16);
        chk("restart_busy_end", 32'(busy[1]), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("no_second_frame", {30'd0, busy[1], m_valid[1]}, 32'd0);
        end

        // Reset mid-frame, then a clean new frame
        start_frame(1, 14'h0000);
        stream_ready(1, 5, 32'h0, 0, 16);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", 32'(m_valid[1]), 32'd0);
        chk("abort_busy", 32'(busy[1]), 32'd0);
        chk("abort_done", 32'(done[1]), 32'd0);
        tick();
        chk("abort_no_done", 32'(done[1]), 32'd0);
        start_frame(1, 14'h0020);
        stream_ready(1, 16, 32'h20, 0, 16);
        chk("post_abort_busy_end", 32'(busy[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
